// File: rtl/disp_page_arbiter.sv
// Round-robin display page arbiter: hands the shared seven-segment display to one
// requesting source at a time for a minimum dwell of HOLD cycles, then rotates.
module disp_page_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned DW    = 16,
    parameter int unsigned HOLD  = 50_000_000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*DW-1:0]        data,
    output logic [N_REQ-1:0]           grant,
    output logic [$clog2(N_REQ)-1:0]   disp_idx,
    output logic [DW-1:0]              disp_val,
    output logic                       disp_valid,
    output logic                       switch_tick
);

    localparam int unsigned IW = $clog2(N_REQ);
    localparam int unsigned CW = $clog2(HOLD);

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [IW-1:0]      last_q, last_d;
    logic [N_REQ-1:0]   grant_d;
    logic [IW-1:0]      idx_d;
    logic [DW-1:0]      val_d;
    logic               valid_d;
    logic               tick_d;

    logic [IW-1:0]      sel_idx_c;
    logic [IW-1:0]      cand_c;
    logic               sel_found_c;
    logic               any_req_c;
    logic               expire_c;
    logic               load_c;

    // Round-robin pick: first requester above the last holder, wrapping; holder is last.
    always_comb begin
        sel_idx_c   = last_q;
        cand_c      = last_q;
        sel_found_c = 1'b0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand_c = IW'((32'(last_q) + k) % N_REQ);
            if (!sel_found_c && req[cand_c]) begin
                sel_idx_c   = cand_c;
                sel_found_c = 1'b1;
            end
        end
    end

    assign any_req_c = |req;
    assign expire_c  = (state_q == SHOW) && (cnt_q == '0);
    assign load_c    = any_req_c && ((state_q == IDLE) || expire_c);

    // State register plus all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_q      <= IW'(N_REQ - 1);
            grant       <= '0;
            disp_idx    <= '0;
            disp_val    <= '0;
            disp_valid  <= 1'b0;
            switch_tick <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            grant       <= grant_d;
            disp_idx    <= idx_d;
            disp_val    <= val_d;
            disp_valid  <= valid_d;
            switch_tick <= tick_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req_c) state_d = SHOW;
            SHOW:    if (expire_c && !any_req_c) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values for the counter, pointer and registered outputs.
    always_comb begin
        cnt_d   = cnt_q;
        last_d  = last_q;
        grant_d = grant;
        idx_d   = disp_idx;
        val_d   = disp_val;
        valid_d = disp_valid;
        tick_d  = 1'b0;
        if (load_c) begin
            cnt_d   = CW'(HOLD - 1);
            last_d  = sel_idx_c;
            grant_d = N_REQ'(1) << sel_idx_c;
            idx_d   = sel_idx_c;
            val_d   = data[32'(sel_idx_c)*DW +: DW];
            valid_d = 1'b1;
            tick_d  = 1'b1;
        end else if ((state_q == SHOW) && !expire_c) begin
            // Holder keeps the display even if its request has dropped.
            cnt_d   = cnt_q - CW'(1);
            val_d   = data[32'(disp_idx)*DW +: DW];
        end else begin
            cnt_d   = '0;
            grant_d = '0;
            idx_d   = '0;
            val_d   = '0;
            valid_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_disp_page_arbiter.sv
// Bench for disp_page_arbiter: directed scenarios plus random traffic, every cycle
// compared against a window-level model of the round-robin dwell behaviour.
module tb_disp_page_arbiter;

    localparam int N    = 4;
    localparam int DW   = 16;
    localparam int HOLD = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req;
    logic [N*DW-1:0]   data;
    logic [N-1:0]      grant;
    logic [1:0]        disp_idx;
    logic [DW-1:0]     disp_val;
    logic              disp_valid;
    logic              switch_tick;

    int checks   = 0;
    int failures = 0;

    // Model: owner (-1 when idle), cycles left in the window, last granted index.
    int          m_owner;
    int          m_left;
    int          m_last;
    logic [15:0] m_val;
    logic        m_tick;

    logic [N-1:0] tick_grants[$];

    always #5 clk = ~clk;

    disp_page_arbiter #(.N_REQ(N), .DW(DW), .HOLD(HOLD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .data        (data),
        .grant       (grant),
        .disp_idx    (disp_idx),
        .disp_val    (disp_val),
        .disp_valid  (disp_valid),
        .switch_tick (switch_tick)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int pick;
        int i;
        pick = -1;
        if (!rst_n) begin
            m_owner = -1; m_left = 0; m_last = N - 1; m_val = '0; m_tick = 1'b0;
        end else if (m_owner < 0 || m_left == 1) begin
            for (int k = 1; k <= N; k++) begin
                i = (m_last + k) % N;
                if (pick < 0 && req[i]) pick = i;
            end
            if (pick >= 0) begin
                m_owner = pick; m_last = pick; m_left = HOLD;
                m_val = data[pick*DW +: DW]; m_tick = 1'b1;
            end else begin
                m_owner = -1; m_left = 0; m_val = '0; m_tick = 1'b0;
            end
        end else begin
            m_left--;
            m_val  = data[m_owner*DW +: DW];
            m_tick = 1'b0;
        end
    endtask

    task automatic compare_all();
        logic [N-1:0] eg;
        eg = (m_owner < 0) ? '0 : (N'(1) << m_owner);
        check("grant",       32'(grant),       32'(eg));
        check("disp_idx",    32'(disp_idx),    (m_owner < 0) ? 32'd0 : 32'(m_owner));
        check("disp_val",    32'(disp_val),    32'(m_val));
        check("disp_valid",  32'(disp_valid),  (m_owner < 0) ? 32'd0 : 32'd1);
        check("switch_tick", 32'(switch_tick), 32'(m_tick));
    endtask

    // One clock: model consumes the inputs the DUT samples, outputs checked mid-cycle.
    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        compare_all();
        if (switch_tick === 1'b1) tick_grants.push_back(grant);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        data  = '0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [N-1:0] rot_exp [5];
        logic [15:0]  d1;
        rot_exp[0] = 4'b0001; rot_exp[1] = 4'b0010; rot_exp[2] = 4'b0100;
        rot_exp[3] = 4'b1000; rot_exp[4] = 4'b0001;
        rst_n = 1'b0; req = '0; data = '0;
        m_owner = -1; m_left = 0; m_last = N - 1; m_val = '0; m_tick = 1'b0;
        @(negedge clk);

        // Single requester: re-granted to itself every window.
        do_reset();
        check("reset_grant", 32'(grant), 32'd0);
        data[0 +: DW] = 16'h1234;
        req = 4'b0001;
        repeat (13) step();

        // Full rotation with every source requesting.
        do_reset();
        for (int i = 0; i < N; i++) data[i*DW +: DW] = 16'hA000 + 16'(i);
        req = 4'b1111;
        tick_grants.delete();
        repeat (20) step();
        check("rot_ticks", 32'(tick_grants.size()), 32'd5);
        for (int i = 0; i < 5 && i < tick_grants.size(); i++)
            check("rot_seq", 32'(tick_grants[i]), 32'(rot_exp[i]));

        // Sparse round-robin.
        do_reset();
        data = {16'hD003, 16'hD002, 16'hD001, 16'hD000};
        req  = 4'b1010;
        repeat (14) step();

        // One-cycle request still gets a full window, then idle.
        do_reset();
        data[2*DW +: DW] = 16'h0BEE;
        req = 4'b0100;
        step();
        req = 4'b0000;
        repeat (6) step();
        check("drop_idle_valid", 32'(disp_valid), 32'd0);

        // Live tracking of a counting source.
        do_reset();
        d1 = 16'h00FF;
        data[DW +: DW] = d1;
        req = 4'b0010;
        step();
        repeat (10) begin
            d1 = d1 + 16'd1;
            data[DW +: DW] = d1;
            step();
        end

        // Reset in the middle of a window.
        do_reset();
        req = 4'b0100;
        step();
        step();
        rst_n = 1'b0;
        step();
        check("rst_mid_grant", 32'(grant), 32'd0);
        rst_n = 1'b1;
        req = 4'b1111;
        step();
        check("rst_first_grant", 32'(grant), 32'd1);

        // Random traffic with occasional resets.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            rst_n = ($urandom_range(0, 63) != 0);
            req   = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
            for (int i = 0; i < N; i++) data[i*DW +: DW] = 16'($urandom);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
